rename_map: RTL

//  Register renamer: RAT plus circular PRN free list. Accepts decoded insts, maps source

---
 rtl/rename_map.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rename_map.sv
// rtl/rename_map.sv - register alias table with circular physical-register free list
// Renames on accept into a single output stage toward the ROB; retired PRNs refill the list tail.
module rename_map #(
  parameter int PRN_BITS     = 6,
  parameter int ARN_COUNT    = 32,
  parameter int MAX_OPERANDS = 3
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    dec_valid_i,
  output logic                                    dec_ready_o,
  input  logic [63:0]                             dec_pc_i,
  input  logic [MAX_OPERANDS-1:0]                 dec_src_valid_i,
  input  logic [MAX_OPERANDS-1:0][5:0]            dec_src_arn_i,
  input  logic [MAX_OPERANDS-1:0]                 dec_dst_valid_i,
  input  logic [MAX_OPERANDS-1:0][5:0]            dec_dst_arn_i,
  output logic                                    ren_valid_o,
  input  logic                                    ren_ready_i,
  output logic [63:0]                             ren_pc_o,
  output logic [MAX_OPERANDS-1:0]                 ren_src_valid_o,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   ren_src_prn_o,
  output logic [MAX_OPERANDS-1:0]                 ren_dst_valid_o,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   ren_dst_prn_o,
  output logic [MAX_OPERANDS-1:0]                 ren_old_valid_o,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   ren_old_prn_o,
  output logic [MAX_OPERANDS-1:0][5:0]            ren_old_arn_o,
  input  logic [MAX_OPERANDS-1:0]                 freed_prns_valid_i,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   freed_prns_i,
  output logic [PRN_BITS:0]                       free_count_o
);
  localparam int M         = MAX_OPERANDS;
  localparam int PRN_COUNT = 1 << PRN_BITS;
  localparam int CNT_W     = PRN_BITS + 1;

  logic [PRN_BITS-1:0] rat_q [ARN_COUNT];
  logic [PRN_BITS-1:0] fl_q  [PRN_COUNT];
  logic [PRN_BITS-1:0] head_q, tail_q;
  logic [CNT_W-1:0]    free_count_q, free_count_d;

  logic                         ren_valid_q;
  logic [63:0]                  ren_pc_q;
  logic [M-1:0]                 ren_src_valid_q, ren_dst_valid_q, ren_old_valid_q;
  logic [M-1:0][PRN_BITS-1:0]   ren_src_prn_q, ren_dst_prn_q, ren_old_prn_q;
  logic [M-1:0][5:0]            ren_old_arn_q;

  logic [CNT_W-1:0]             ndst, npush;
  logic [M-1:0][PRN_BITS-1:0]   src_prn, old_prn, new_prn, push_idx;
  logic [M-1:0][5:0]            old_arn;
  logic [PRN_BITS-1:0]          pop_idx;
  logic                         accept, dup_dst;

  // All lookups see the RAT before this inst's writes, so sources never bypass own dests.
  always_comb begin
    ndst    = '0;
    npush   = '0;
    pop_idx = '0;
    dup_dst = 1'b0;
    for (int i = 0; i < M; i++) begin
      src_prn[i]  = '0;
      old_prn[i]  = '0;
      old_arn[i]  = '0;
      new_prn[i]  = '0;
      push_idx[i] = tail_q + npush[PRN_BITS-1:0];
      for (int a = 0; a < ARN_COUNT; a++) begin
        if (dec_src_valid_i[i] && dec_src_arn_i[i] == 6'(a)) src_prn[i] = rat_q[a];
        if (dec_dst_valid_i[i] && dec_dst_arn_i[i] == 6'(a)) old_prn[i] = rat_q[a];
      end
      if (dec_dst_valid_i[i]) begin
        pop_idx    = head_q + ndst[PRN_BITS-1:0];
        old_arn[i] = dec_dst_arn_i[i];
        new_prn[i] = fl_q[pop_idx];
        ndst       = ndst + CNT_W'(1);
      end
      if (freed_prns_valid_i[i]) npush = npush + CNT_W'(1);
      for (int j = 0; j < i; j++) begin
        if (dec_dst_valid_i[i] && dec_dst_valid_i[j] && dec_dst_arn_i[i] == dec_dst_arn_i[j])
          dup_dst = 1'b1;
      end
    end
  end

  assign dec_ready_o  = !rst_i && (!ren_valid_q || ren_ready_i) && (free_count_q >= ndst);
  assign accept       = dec_valid_i && dec_ready_o;
  assign free_count_d = free_count_q + npush - (accept ? ndst : '0);

  for (genvar a = 0; a < ARN_COUNT; a++) begin : g_rat
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rat_q[a] <= PRN_BITS'(a);
      end else if (accept) begin
        for (int i = 0; i < M; i++) begin
          if (dec_dst_valid_i[i] && dec_dst_arn_i[i] == 6'(a)) rat_q[a] <= new_prn[i];
        end
      end
    end
  end

  // Entries past the initial free range are don't-care; the wrapped value keeps reset simple.
  for (genvar p = 0; p < PRN_COUNT; p++) begin : g_fl
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        fl_q[p] <= PRN_BITS'((p + ARN_COUNT) % PRN_COUNT);
      end else begin
        for (int i = 0; i < M; i++) begin
          if (freed_prns_valid_i[i] && push_idx[i] == PRN_BITS'(p)) fl_q[p] <= freed_prns_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q          <= '0;
      tail_q          <= PRN_BITS'((PRN_COUNT - ARN_COUNT) % PRN_COUNT);
      free_count_q    <= CNT_W'(PRN_COUNT - ARN_COUNT);
      ren_valid_q     <= 1'b0;
      ren_pc_q        <= '0;
      ren_src_valid_q <= '0;
      ren_src_prn_q   <= '0;
      ren_dst_valid_q <= '0;
      ren_dst_prn_q   <= '0;
      ren_old_valid_q <= '0;
      ren_old_prn_q   <= '0;
      ren_old_arn_q   <= '0;
    end else begin
      tail_q       <= tail_q + npush[PRN_BITS-1:0];
      free_count_q <= free_count_d;
      if (accept) begin
        head_q          <= head_q + ndst[PRN_BITS-1:0];
        ren_valid_q     <= 1'b1;
        ren_pc_q        <= dec_pc_i;
        ren_src_valid_q <= dec_src_valid_i;
        ren_src_prn_q   <= src_prn;
        ren_dst_valid_q <= dec_dst_valid_i;
        ren_dst_prn_q   <= new_prn;
        ren_old_valid_q <= dec_dst_valid_i;
        ren_old_prn_q   <= old_prn;
        ren_old_arn_q   <= old_arn;
      end else if (ren_ready_i) begin
        ren_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(accept && dup_dst));
      assert ((free_count_q + npush) <= CNT_W'(PRN_COUNT));
    end
  end

  assign ren_valid_o     = ren_valid_q;
  assign ren_pc_o        = ren_pc_q;
  assign ren_src_valid_o = ren_src_valid_q;
  assign ren_src_prn_o   = ren_src_prn_q;
  assign ren_dst_valid_o = ren_dst_valid_q;
  assign ren_dst_prn_o   = ren_dst_prn_q;
  assign ren_old_valid_o = ren_old_valid_q;
  assign ren_old_prn_o   = ren_old_prn_q;
  assign ren_old_arn_o   = ren_old_arn_q;
  assign free_count_o    = free_count_q;

endmodule
